anim_sprite_src: RTL and testbench
==================================

ANIM_SPRITE_SRC -- requirements
Module: anim_sprite_src

Interface
REQ-001 The block SHALL have parameter CD, default 12, meaning pixel colour depth in bits.
REQ-002 The block SHALL have parameter HB, default 5, meaning log2 of sprite width (H_SIZE = 2**HB).
REQ-003 The block SHALL have parameter VB, default 5, meaning log2 of sprite height (V_SIZE = 2**VB).
REQ-004 The block SHALL have parameter FB, default 2, meaning log2 of frame count (N_FRAMES = 2**FB).
REQ-005 The block SHALL have parameter KEY_COLOR, default 0, meaning chroma-key (transparent) value.
REQ-006 Ports SHALL be exactly the following:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- x, y  in  11 each  current pixel coordinate.
- x0, y0  in  11 each  sprite origin.
- flip_h, flip_v  in  1 each  mirror sprite horizontally / vertically.
- frame_tick  in  1  one-cycle pulse at start of each video frame.
- anim_run  in  1  1 = auto-animate; 0 = show frame_sel.
- anim_pingpong  in  1  0 = loop, 1 = ping-pong sequence.
- anim_div  in  8  frame_ticks per animation step; 0 = hold.
- frame_sel  in  FB  static frame when anim_run = 0.
- we  in  1  sprite RAM write enable.
- addr_w  in  FB+VB+HB  write address {frame, row, col}.
- pixel_in  in  CD  write data.
- sprite_rgb  out  CD  pixel colour, KEY_COLOR when outside or transparent.
- hit  out  1  in region and pixel != KEY_COLOR.
- cur_frame  out  FB  frame currently displayed.

Function
REQ-007 xr = x - x0 and yr = y - y0 SHALL be computed as 12-bit signed values; in_region SHALL be 0 <= xr < H_SIZE and 0 <= yr < V_SIZE.
REQ-008 Column SHALL be xr[HB-1:0], inverted bitwise when flip_h = 1; row SHALL be yr[VB-1:0], inverted when flip_v = 1.
REQ-009 Read address SHALL be {cur_frame, row, col}; the RAM SHALL have a synchronous read (1 cycle).
REQ-010 in_region SHALL be delayed 1 cycle to align with RAM data; sprite_rgb and hit SHALL be registered, giving a fixed 2-cycle latency from x/y to output.
REQ-011 Out of region, sprite_rgb SHALL be KEY_COLOR and hit SHALL be 0.
REQ-012 A tick counter SHALL increment on each frame_tick while anim_run = 1 and anim_div != 0; when it equals anim_div-1 it SHALL clear and advance the frame.
REQ-013 Loop mode SHALL advance 0,1,...,N_FRAMES-1,0.
REQ-014 Ping-pong mode SHALL use a direction flag: count up to N_FRAMES-1, then down to 0, then up; endpoints are not repeated. With N_FRAMES = 1 the frame SHALL stay at 0.
REQ-015 Changing anim_pingpong mid-sequence SHALL clear the direction flag to up on the next step if the frame is N_FRAMES-1 in loop mode (wraps to 0).
REQ-016 With anim_run = 0, cur_frame SHALL load frame_sel on the next frame_tick only, and the tick counter and direction flag SHALL clear; frame changes SHALL never occur except on a frame_tick.
REQ-017 anim_div = 0 SHALL hold cur_frame and the tick counter.
REQ-018 A write SHALL land at addr_w on the clock edge; a read of the same address in the same cycle SHALL return the old data.

Reset
REQ-019 On reset_n = 0 (asynchronous), sprite_rgb SHALL be KEY_COLOR, hit 0, cur_frame 0, tick counter 0, direction up, pipeline valid bits 0; RAM contents are not reset.
REQ-020 Reset deassertion SHALL be synchronised by the system; the first frame_tick after reset SHALL count as tick 1.

Structure
REQ-021 A package sprite_pkg SHALL hold the KEY_COLOR default, the coordinate width (11) and an enum anim_dir_t {DIR_UP, DIR_DOWN}.
REQ-022 One sub-module, sprite_frame_ram (dual-port, sync write, sync read, parametrised by address and data width), SHALL hold the frame store.

Verification
REQ-023 x0 = 100, y0 = 50, write frame 0 pixel (row 2, col 3) = 0xF00, sweep x = 103, y = 52 -> sprite_rgb = 0xF00, hit = 1 exactly 2 cycles later.
REQ-024 Same pixel, flip_h = 1 -> 0xF00 appears at x = 100+28 = 128; x = 132 -> KEY_COLOR, hit = 0.
REQ-025 anim_run = 1, anim_div = 3, loop, FB = 2 -> cur_frame 0,1,2,3,0 changing on ticks 3,6,9,12.
REQ-026 Ping-pong, anim_div = 1 -> cur_frame 0,1,2,3,2,1,0,1 on successive frame_ticks.
REQ-027 Pixel stored equal to KEY_COLOR inside region -> sprite_rgb = KEY_COLOR, hit = 0.
REQ-028 reset_n pulsed low mid-animation at frame 2 -> outputs KEY_COLOR/0 immediately, cur_frame = 0; anim_run = 0, frame_sel = 3 -> cur_frame = 3 only after the next frame_tick.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the animated sprite source.
package sprite_pkg;

    localparam int COORD_W       = 11;
    localparam int KEY_COLOR_DEF = 0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } anim_dir_t;

    // True when a sign-extended coordinate difference lies in [0, 2**b).
    function automatic logic in_window(input logic [COORD_W:0] d, input int b);
        return (d[COORD_W] == 1'b0) && (int'(d) < (1 << b));
    endfunction

endpackage

// File: rtl/sprite_frame_ram.sv
// Simple dual-port frame store: synchronous write, registered read (read-before-write).
module sprite_frame_ram #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Non-blocking update means a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/anim_sprite_src.sv
// Animated, flippable, chroma-keyed sprite pixel source with a 2-cycle pixel pipeline.
module anim_sprite_src
    import sprite_pkg::*;
#(
    parameter int           CD        = 12,
    parameter int           HB        = 5,
    parameter int           VB        = 5,
    parameter int           FB        = 2,
    parameter logic [CD-1:0] KEY_COLOR = CD'(KEY_COLOR_DEF)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic [COORD_W-1:0]    x0,
    input  logic [COORD_W-1:0]    y0,
    input  logic                  flip_h,
    input  logic                  flip_v,
    input  logic                  frame_tick,
    input  logic                  anim_run,
    input  logic                  anim_pingpong,
    input  logic [7:0]            anim_div,
    input  logic [FB-1:0]         frame_sel,
    input  logic                  we,
    input  logic [FB+VB+HB-1:0]   addr_w,
    input  logic [CD-1:0]         pixel_in,
    output logic [CD-1:0]         sprite_rgb,
    output logic                  hit,
    output logic [FB-1:0]         cur_frame
);

    localparam int AW       = FB + VB + HB;
    localparam int N_FRAMES = 1 << FB;
    localparam logic [FB-1:0] FRAME_MAX = {FB{1'b1}};

    logic [COORD_W:0] xr, yr;
    logic             in_region;
    logic [HB-1:0]    col;
    logic [VB-1:0]    row;
    logic [AW-1:0]    raddr;
    logic [CD-1:0]    rdata;

    logic             in_region_d_reg;
    logic [CD-1:0]    sprite_rgb_reg;
    logic             hit_reg;

    logic [FB-1:0]    frame_reg, frame_next;
    logic [7:0]       tick_reg, tick_next;
    anim_dir_t        dir_reg, dir_next;

    // Zero-extended subtraction gives the 12-bit signed offset from the origin.
    assign xr        = {1'b0, x} - {1'b0, x0};
    assign yr        = {1'b0, y} - {1'b0, y0};
    assign in_region = in_window(xr, HB) && in_window(yr, VB);
    assign col       = xr[HB-1:0] ^ {HB{flip_h}};
    assign row       = yr[VB-1:0] ^ {VB{flip_v}};
    assign raddr     = {frame_reg, row, col};

    sprite_frame_ram #(
        .AW (AW),
        .DW (CD)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr_w),
        .wdata (pixel_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_region_d_reg <= 1'b0;
            sprite_rgb_reg  <= KEY_COLOR;
            hit_reg         <= 1'b0;
        end else begin
            in_region_d_reg <= in_region;
            sprite_rgb_reg  <= in_region_d_reg ? rdata : KEY_COLOR;
            hit_reg         <= in_region_d_reg && (rdata != KEY_COLOR);
        end
    end

    // Frame sequencer: every change is gated by frame_tick.
    always_comb begin
        frame_next = frame_reg;
        tick_next  = tick_reg;
        dir_next   = dir_reg;
        if (frame_tick) begin
            if (!anim_run) begin
                frame_next = frame_sel;
                tick_next  = 8'd0;
                dir_next   = DIR_UP;
            end else if (anim_div != 8'd0) begin
                if (tick_reg == anim_div - 8'd1) begin
                    tick_next = 8'd0;
                    if (!anim_pingpong) begin
                        frame_next = frame_reg + FB'(1);
                        dir_next   = DIR_UP;
                    end else if (N_FRAMES > 1) begin
                        if (dir_reg == DIR_UP) begin
                            if (frame_reg == FRAME_MAX) begin
                                frame_next = frame_reg - FB'(1);
                                dir_next   = DIR_DOWN;
                            end else begin
                                frame_next = frame_reg + FB'(1);
                            end
                        end else if (frame_reg == '0) begin
                            frame_next = frame_reg + FB'(1);
                            dir_next   = DIR_UP;
                        end else begin
                            frame_next = frame_reg - FB'(1);
                        end
                    end
                end else begin
                    tick_next = tick_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_reg <= '0;
            tick_reg  <= 8'd0;
            dir_reg   <= DIR_UP;
        end else begin
            frame_reg <= frame_next;
            tick_reg  <= tick_next;
            dir_reg   <= dir_next;
        end
    end

    assign sprite_rgb = sprite_rgb_reg;
    assign hit        = hit_reg;
    assign cur_frame  = frame_reg;

endmodule

// File: tb/tb_anim_sprite_src.sv
// Self-checking bench for anim_sprite_src: pixel vectors via a scoreboard, animation sequences inline.
module tb_anim_sprite_src;

    localparam int CD = 12;
    localparam int HB = 5;
    localparam int VB = 5;
    localparam int FB = 2;
    localparam int AW = FB + VB + HB;
    localparam int HS = 1 << HB;
    localparam int VS = 1 << VB;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [10:0]    x, y, x0, y0;
    logic           flip_h, flip_v, frame_tick, anim_run, anim_pingpong;
    logic [7:0]     anim_div;
    logic [FB-1:0]  frame_sel;
    logic           we;
    logic [AW-1:0]  addr_w;
    logic [CD-1:0]  pixel_in;
    logic [CD-1:0]  sprite_rgb;
    logic           hit;
    logic [FB-1:0]  cur_frame;

    anim_sprite_src dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .x             (x),
        .y             (y),
        .x0            (x0),
        .y0            (y0),
        .flip_h        (flip_h),
        .flip_v        (flip_v),
        .frame_tick    (frame_tick),
        .anim_run      (anim_run),
        .anim_pingpong (anim_pingpong),
        .anim_div      (anim_div),
        .frame_sel     (frame_sel),
        .we            (we),
        .addr_w        (addr_w),
        .pixel_in      (pixel_in),
        .sprite_rgb    (sprite_rgb),
        .hit           (hit),
        .cur_frame     (cur_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    typedef struct {
        int            due;
        logic [CD-1:0] rgb;
        logic          hit;
        int            tag;
    } exp_t;
    exp_t sbq[$];

    // Scoreboard: compare each queued pixel exactly on its due cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            check($sformatf("pix%0d rgb", sbq[0].tag), int'(sprite_rgb), int'(sbq[0].rgb));
            check($sformatf("pix%0d hit", sbq[0].tag), int'(hit), int'(sbq[0].hit));
            void'(sbq.pop_front());
        end
    end

    logic [CD-1:0] mem_m [0:(1<<AW)-1];

    function automatic logic [CD-1:0] pat(input int a);
        logic [CD-1:0] v;
        v = CD'(a);
        return v ^ 12'hA5A;
    endfunction

    function automatic void model(input int xx, input int yy, input int ox, input int oy,
                                  input int fh, input int fv, input int fr,
                                  output logic [CD-1:0] rgb, output logic h);
        int dx, dy, c, r;
        dx = xx - ox;
        dy = yy - oy;
        rgb = '0;
        h = 1'b0;
        if (dx >= 0 && dx < HS && dy >= 0 && dy < VS) begin
            c = (fh != 0) ? (HS - 1 - dx) : dx;
            r = (fv != 0) ? (VS - 1 - dy) : dy;
            rgb = mem_m[fr * HS * VS + r * HS + c];
            h = (rgb != '0);
        end
    endfunction

    task automatic expect_pix(input logic [CD-1:0] r, input logic h, input int tag);
        exp_t e;
        e.due = cyc + 2;
        e.rgb = r;
        e.hit = h;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic drive(input int xx, input int yy, input int ox, input int oy,
                         input int fh, input int fv);
        x = 11'(xx);
        y = 11'(yy);
        x0 = 11'(ox);
        y0 = 11'(oy);
        flip_h = fh[0];
        flip_v = fv[0];
    endtask

    task automatic wr(input int a, input logic [CD-1:0] d);
        we = 1'b1;
        addr_w = AW'(a);
        pixel_in = d;
        mem_m[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic tick_chk(input int exp, input string nm);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check(nm, int'(cur_frame), exp);
        @(negedge clk);
    endtask

    typedef struct {
        int x, y, x0, y0, fh, fv, rgb, hit;
    } vec_t;
    vec_t tbl[12];

    logic [CD-1:0] er;
    logic          eh;
    int            pp[7];

    initial begin
        tbl[0]  = '{103,  52, 100, 50, 0, 0, 'hF00, 1};
        tbl[1]  = '{128,  52, 100, 50, 1, 0, 'hF00, 1};
        tbl[2]  = '{132,  52, 100, 50, 1, 0, 'h000, 0};
        tbl[3]  = '{ 99,  52, 100, 50, 0, 0, 'h000, 0};
        tbl[4]  = '{131,  81, 100, 50, 0, 0, 'h9A5, 1};
        tbl[5]  = '{103,  49, 100, 50, 0, 0, 'h000, 0};
        tbl[6]  = '{100,  82, 100, 50, 0, 0, 'h000, 0};
        tbl[7]  = '{105,  55, 100, 50, 0, 0, 'h000, 0};
        tbl[8]  = '{103,  79, 100, 50, 0, 1, 'hF00, 1};
        tbl[9]  = '{  5,  52, 2000, 50, 0, 0, 'h000, 0};
        tbl[10] = '{2040,  0, 2020,  0, 0, 0, 'hA4E, 1};
        tbl[11] = '{100,  50, 100, 50, 1, 1, 'h9A5, 1};
        pp = '{1, 2, 3, 2, 1, 0, 1};

        drive(0, 0, 1000, 1000, 0, 0);
        frame_tick = 1'b0;
        anim_run = 1'b0;
        anim_pingpong = 1'b0;
        anim_div = 8'd0;
        frame_sel = '0;
        we = 1'b0;
        addr_w = '0;
        pixel_in = '0;

        repeat (3) @(negedge clk);
        check("rst rgb", int'(sprite_rgb), 0);
        check("rst hit", int'(hit), 0);
        check("rst frame", int'(cur_frame), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < (1 << AW); a++) begin
            we = 1'b1;
            addr_w = AW'(a);
            pixel_in = pat(a);
            mem_m[a] = pat(a);
            @(negedge clk);
        end
        we = 1'b0;
        wr(2 * HS + 3, 12'hF00);
        wr(5 * HS + 5, 12'h000);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].x0, tbl[i].y0, tbl[i].fh, tbl[i].fv);
            expect_pix(CD'(tbl[i].rgb), tbl[i].hit[0], i);
            @(negedge clk);
        end
        drain();

        for (int i = 0; i < 40; i++) begin
            int xx, yy, fh, fv;
            xx = int'($urandom_range(135, 95));
            yy = int'($urandom_range(85, 45));
            fh = int'($urandom_range(1, 0));
            fv = int'($urandom_range(1, 0));
            drive(xx, yy, 100, 50, fh, fv);
            model(xx, yy, 100, 50, fh, fv, 0, er, eh);
            expect_pix(er, eh, 100 + i);
            @(negedge clk);
        end
        drain();

        // Same-cycle write and read of one word: old data first, new data next.
        drive(103, 52, 100, 50, 0, 0);
        we = 1'b1;
        addr_w = AW'(2 * HS + 3);
        pixel_in = 12'h123;
        expect_pix(12'hF00, 1'b1, 200);
        @(negedge clk);
        we = 1'b0;
        mem_m[2 * HS + 3] = 12'h123;
        expect_pix(12'h123, 1'b1, 201);
        @(negedge clk);
        drive(0, 0, 1000, 1000, 0, 0);
        drain();

        anim_run = 1'b1;
        anim_pingpong = 1'b0;
        anim_div = 8'd3;
        for (int n = 1; n <= 12; n++) begin
            tick_chk((n / 3) % 4, $sformatf("loop tick%0d", n));
        end
        repeat (5) @(negedge clk);
        check("no tick hold", int'(cur_frame), 0);

        anim_pingpong = 1'b1;
        anim_div = 8'd1;
        for (int n = 0; n < 7; n++) begin
            tick_chk(pp[n], $sformatf("pp tick%0d", n + 1));
        end

        anim_div = 8'd0;
        for (int n = 0; n < 3; n++) begin
            tick_chk(1, $sformatf("div0 tick%0d", n + 1));
        end

        anim_div = 8'd1;
        tick_chk(2, "pp up a");
        tick_chk(3, "pp up b");
        tick_chk(2, "pp down");
        anim_pingpong = 1'b0;
        tick_chk(3, "sw loop a");
        tick_chk(0, "sw loop b");
        tick_chk(1, "sw loop c");
        anim_pingpong = 1'b1;
        tick_chk(2, "sw pp dir up");

        // Pixel from frame 2 is showing, then an asynchronous reset mid-cycle.
        drive(4, 1, 0, 0, 0, 0);
        model(4, 1, 0, 0, 0, 0, 2, er, eh);
        for (int i = 0; i < 3; i++) begin
            expect_pix(er, eh, 300 + i);
            @(negedge clk);
        end
        drain();
        check("pre rst hit", int'(hit), 1);
        #2;
        reset_n = 1'b0;
        anim_pingpong = 1'b0;
        anim_div = 8'd2;
        #1;
        check("async rst rgb", int'(sprite_rgb), 0);
        check("async rst hit", int'(hit), 0);
        check("async rst frame", int'(cur_frame), 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 1000, 1000, 0, 0);
        @(negedge clk);
        check("post rst frame", int'(cur_frame), 0);
        tick_chk(0, "rst tick1");
        tick_chk(1, "rst tick2");

        anim_div = 8'd3;
        tick_chk(1, "cnt a");
        tick_chk(1, "cnt b");
        anim_run = 1'b0;
        frame_sel = 2'd3;
        repeat (4) @(negedge clk);
        check("sel waits tick", int'(cur_frame), 1);
        tick_chk(3, "sel on tick");
        anim_run = 1'b1;
        tick_chk(3, "cnt clr a");
        tick_chk(3, "cnt clr b");
        tick_chk(0, "cnt clr c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
